pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline: FETCH, DECODE, ALU, MEMORYACCESS, WRITEBACK.
- Owns the per-stage valid/enable registers that drive i_memoryaccess_ce and i_writeback_ce of the operand-forwarding unit.
- Turns the forwarding unit's o_alu_force_stall, memory busy signals, branch flushes and trap requests into consistent per-stage ce/stall/flush controls.
- Includes an entry sequence after reset, a trap drain FSM, and stall performance/watchdog counters.

Parameters:
- STALL_TIMEOUT, 1024, consecutive ALU-stall cycles before o_stall_timeout is set.
- CNT_WIDTH, 32, width of the stall performance counter.

Ports:
- i_clk  input  1  single clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_alu_force_stall  input  1  load/CSR-use stall from the forwarding unit.
- i_imem_busy  input  1  instruction memory has not returned a fetch this cycle.
- i_dmem_busy  input  1  data memory access in MEMORYACCESS not complete.
- i_flush_req  input  1  taken branch/jump resolved in ALU stage.
- i_trap_req  input  1  exception/interrupt accepted in ALU stage.
- o_fetch_ce, o_decoder_ce, o_alu_ce, o_memoryaccess_ce, o_writeback_ce  output  1 each  stage-valid registers.
- o_fetch_stall, o_decoder_stall, o_alu_stall, o_memoryaccess_stall  output  1 each  hold stage registers.
- o_decoder_flush, o_alu_flush  output  1 each  kill younger instructions.
- o_pc_redirect  output  1  load PC from branch/trap target this cycle.
- o_trap_busy  output  1  high while the FSM is in DRAIN.
- o_stall_cycles  output  CNT_WIDTH  count of cycles with o_alu_stall high.
- o_stall_timeout  output  1  sticky watchdog flag.

Behaviour:
- Reset (async, i_rst_n=0): all ce outputs=0, all stall and flush outputs=0, o_pc_redirect=0, o_trap_busy=0, counters=0, o_stall_timeout=0, state=IDLE.
- FSM states and transitions:
  - IDLE -> RUN after 1 cycle. o_fetch_ce rises on the first RUN cycle.
  - RUN -> FLUSH on i_flush_req & ~o_alu_stall.
  - RUN -> DRAIN on i_trap_req & ~o_alu_stall.
  - FLUSH -> RUN after exactly 1 cycle.
  - DRAIN -> RUN when o_memoryaccess_ce=0 and o_writeback_ce=0.
- Stall chain (combinational from inputs and valid registers):
  - smem = i_dmem_busy & o_memoryaccess_ce
  - salu = smem | (i_alu_force_stall & o_alu_ce)
  - sdec = salu
  - sfet = sdec | i_imem_busy
  - Outputs o_memoryaccess_stall=smem, o_alu_stall=salu, o_decoder_stall=sdec, o_fetch_stall=sfet.
- Valid propagation (registered, RUN state):
  - wb <= mem & ~smem
  - mem <= smem ? mem : (alu & ~salu)
  - alu <= salu ? alu : dec
  - dec <= sdec ? dec : (fet & ~i_imem_busy)
  - fet <= 1
  - A stalled stage with a non-stalled successor inserts a bubble (successor valid=0).
- Branch flush (entering FLUSH):
  - Same cycle: o_pc_redirect=1, o_decoder_flush=1, o_alu_flush=1.
  - Next edge: dec <= 0, alu <= 0; the branch itself advances to MEMORYACCESS.
  - A flush while salu=1 is ignored; the requester holds it.
- Trap (entering DRAIN):
  - Same cycle: o_pc_redirect=1 and both flush outputs high.
  - The trapping instruction is killed (mem <= 0); fet, dec, alu <= 0 and stay 0 through DRAIN.
  - The MEMORYACCESS/WRITEBACK occupants complete normally.
- Simultaneous events:
  - i_trap_req beats i_flush_req.
  - i_flush_req/i_trap_req in FLUSH or DRAIN is ignored.
  - smem freezes DRAIN progress.
- Counters:
  - o_stall_cycles increments every cycle o_alu_stall=1 and wraps at 2^CNT_WIDTH.
  - A consecutive-stall counter clears whenever o_alu_stall=0.
  - When it reaches STALL_TIMEOUT, o_stall_timeout sets and stays set until reset.
- Reset mid-operation: everything returns to reset values asynchronously; no pending flush or trap survives.

Decomposition:
- Shared package/header (alongside the existing pipeline header): stage index constants (FETCH=0 … WRITEBACK=4) and FSM state encodings (IDLE, RUN, FLUSH, DRAIN, 2-bit).
- One sub-module, stall_watchdog: the perf counter plus the consecutive-stall counter and sticky timeout.
- Stall chain and FSM stay in the top module.

Test Plan:
- Release reset, no stalls -> ce bits rise one stage per cycle: fetch at cycle 1, writeback at cycle 5; o_stall_cycles=0.
- Full pipe, i_alu_force_stall=1 for 1 cycle -> fetch/decoder/alu stalls high, memoryaccess_ce=0 next cycle (bubble); o_stall_cycles=1.
- Full pipe, i_flush_req=1 for 1 cycle -> o_pc_redirect=1 that cycle; decoder_ce=alu_ce=0 next cycle; memoryaccess_ce=1; back to RUN after 1 cycle.
- Full pipe, i_trap_req=1 with i_dmem_busy=1 for 3 cycles -> o_trap_busy high until MEMORYACCESS and WRITEBACK drain (5 cycles total); fetch_ce stays 0 throughout, then resumes.
- i_alu_force_stall=1 held for STALL_TIMEOUT=8 cycles -> o_stall_timeout=1 at cycle 8 and stays 1 after the stall drops.
- Assert i_rst_n=0 mid-DRAIN -> all outputs 0 immediately; IDLE->RUN restarts cleanly.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices
// into the per-stage valid vector and the sequencer state encoding.
package pipeline_hazard_ctrl_pkg;

  localparam int NUM_STAGES         = 5;
  localparam int STAGE_FETCH        = 0;
  localparam int STAGE_DECODE       = 1;
  localparam int STAGE_ALU          = 2;
  localparam int STAGE_MEMORYACCESS = 3;
  localparam int STAGE_WRITEBACK    = 4;

  // IDLE: one cycle after reset before fetching starts.
  // RUN: normal operation, the only state that accepts flush/trap requests.
  // FLUSH: one cycle after a taken branch redirect.
  // DRAIN: trap accepted, waiting for MEMORYACCESS/WRITEBACK to empty.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_stall_watchdog.sv
// Stall performance counter plus a consecutive-stall watchdog with a
// sticky timeout flag. The performance counter wraps naturally; the
// consecutive counter saturates at the limit so it can never wrap back
// below it while a stall persists.
module pipeline_hazard_ctrl_stall_watchdog
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_stall,
  output logic [CNT_WIDTH-1:0] o_stall_cycles,
  output logic                 o_stall_timeout
);

  localparam int RUN_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(STALL_TIMEOUT);

  logic [CNT_WIDTH-1:0] perf_q, perf_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic                 timeout_q, timeout_d;

  // Next-state for the counters: count stall cycles, restart the run on any
  // non-stall cycle, and latch the timeout once the run reaches the limit.
  always_comb begin
    perf_d    = perf_q;
    run_d     = '0;
    timeout_d = timeout_q;
    if (i_stall) begin
      perf_d = perf_q + CNT_WIDTH'(1);
      run_d  = (run_q == RUN_LIMIT) ? run_q : run_q + RUN_W'(1);
    end
    if (run_d == RUN_LIMIT) begin
      timeout_d = 1'b1;
    end
  end

  // Counter registers, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      perf_q    <= '0;
      run_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      perf_q    <= perf_d;
      run_q     <= run_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_stall_cycles  = perf_q;
  assign o_stall_timeout = timeout_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Owns the
// per-stage valid registers, derives the stall chain from memory busy and
// the forwarding unit's stall, and sequences branch flushes and trap drains.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_alu_force_stall,
  input  logic                 i_imem_busy,
  input  logic                 i_dmem_busy,
  input  logic                 i_flush_req,
  input  logic                 i_trap_req,
  output logic                 o_fetch_ce,
  output logic                 o_decoder_ce,
  output logic                 o_alu_ce,
  output logic                 o_memoryaccess_ce,
  output logic                 o_writeback_ce,
  output logic                 o_fetch_stall,
  output logic                 o_decoder_stall,
  output logic                 o_alu_stall,
  output logic                 o_memoryaccess_stall,
  output logic                 o_decoder_flush,
  output logic                 o_alu_flush,
  output logic                 o_pc_redirect,
  output logic                 o_trap_busy,
  output logic [CNT_WIDTH-1:0] o_stall_cycles,
  output logic                 o_stall_timeout
);

  hz_state_e             state_q, state_d;
  logic [NUM_STAGES-1:0] valid_q, valid_d;

  logic smem, salu, sdec, sfet;
  logic accept_trap, accept_flush;
  logic pc_redirect, decoder_flush, alu_flush;

  // Stall chain: a stall at a stage also holds every older stage.
  always_comb begin
    smem = i_dmem_busy & valid_q[STAGE_MEMORYACCESS];
    salu = smem | (i_alu_force_stall & valid_q[STAGE_ALU]);
    sdec = salu;
    sfet = sdec | i_imem_busy;
  end

  // Request acceptance: only in RUN and only when the ALU stage can move;
  // a trap wins over a simultaneous branch flush.
  always_comb begin
    accept_trap  = (state_q == ST_RUN) & i_trap_req & ~salu;
    accept_flush = (state_q == ST_RUN) & i_flush_req & ~i_trap_req & ~salu;
  end

  // Next state, next stage valids and the same-cycle redirect/flush pulses.
  always_comb begin
    state_d       = state_q;
    pc_redirect   = 1'b0;
    decoder_flush = 1'b0;
    alu_flush     = 1'b0;

    // Default valid propagation; a held stage in front of a moving stage
    // leaves a bubble behind it.
    valid_d[STAGE_FETCH]        = 1'b1;
    valid_d[STAGE_DECODE]       = sdec ? valid_q[STAGE_DECODE]
                                       : (valid_q[STAGE_FETCH] & ~i_imem_busy);
    valid_d[STAGE_ALU]          = salu ? valid_q[STAGE_ALU] : valid_q[STAGE_DECODE];
    valid_d[STAGE_MEMORYACCESS] = smem ? valid_q[STAGE_MEMORYACCESS]
                                       : (valid_q[STAGE_ALU] & ~salu);
    valid_d[STAGE_WRITEBACK]    = valid_q[STAGE_MEMORYACCESS] & ~smem;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (accept_trap) begin
          // The trapping instruction sits in ALU and never reaches
          // MEMORYACCESS; everything younger is discarded too.
          state_d                     = ST_DRAIN;
          pc_redirect                 = 1'b1;
          decoder_flush               = 1'b1;
          alu_flush                   = 1'b1;
          valid_d[STAGE_FETCH]        = 1'b0;
          valid_d[STAGE_DECODE]       = 1'b0;
          valid_d[STAGE_ALU]          = 1'b0;
          valid_d[STAGE_MEMORYACCESS] = 1'b0;
        end else if (accept_flush) begin
          // The branch itself moves on to MEMORYACCESS; only the two
          // wrong-path instructions behind it are killed.
          state_d               = ST_FLUSH;
          pc_redirect           = 1'b1;
          decoder_flush         = 1'b1;
          alu_flush             = 1'b1;
          valid_d[STAGE_DECODE] = 1'b0;
          valid_d[STAGE_ALU]    = 1'b0;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      ST_DRAIN: begin
        // Front of the pipe stays empty until the older instructions have
        // retired; fetch restarts on the first RUN cycle.
        valid_d[STAGE_FETCH]  = 1'b0;
        valid_d[STAGE_DECODE] = 1'b0;
        valid_d[STAGE_ALU]    = 1'b0;
        if (!valid_q[STAGE_MEMORYACCESS] && !valid_q[STAGE_WRITEBACK]) begin
          state_d              = ST_RUN;
          valid_d[STAGE_FETCH] = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and valid registers, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  pipeline_hazard_ctrl_stall_watchdog #(
    .STALL_TIMEOUT (STALL_TIMEOUT),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_stall_watchdog (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_stall         (salu),
    .o_stall_cycles  (o_stall_cycles),
    .o_stall_timeout (o_stall_timeout)
  );

  assign o_fetch_ce           = valid_q[STAGE_FETCH];
  assign o_decoder_ce         = valid_q[STAGE_DECODE];
  assign o_alu_ce             = valid_q[STAGE_ALU];
  assign o_memoryaccess_ce    = valid_q[STAGE_MEMORYACCESS];
  assign o_writeback_ce       = valid_q[STAGE_WRITEBACK];
  assign o_fetch_stall        = sfet;
  assign o_decoder_stall      = sdec;
  assign o_alu_stall          = salu;
  assign o_memoryaccess_stall = smem;
  assign o_decoder_flush      = decoder_flush;
  assign o_alu_flush          = alu_flush;
  assign o_pc_redirect        = pc_redirect;
  assign o_trap_busy          = (state_q == ST_DRAIN);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a
// randomized run, all compared against a stage-occupancy reference model.
module tb_pipeline_hazard_ctrl;

  localparam int TO = 8;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_req = 1'b0, trap_req = 1'b0, force_stall = 1'b0;
  logic imem_busy = 1'b0, dmem_busy = 1'b0;

  logic fetch_ce, decoder_ce, alu_ce, memoryaccess_ce, writeback_ce;
  logic fetch_stall, decoder_stall, alu_stall, memoryaccess_stall;
  logic decoder_flush, alu_flush, pc_redirect, trap_busy, stall_timeout;
  logic [CW-1:0] stall_cycles;

  logic [13:0] dut_vec;
  logic [4:0]  ce_vec;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: occupancy of each stage (0=fetch .. 4=writeback),
  // sequencing mode (0 boot, 1 run, 2 after-branch, 3 draining) and counters.
  bit m_v[5];
  int m_mode;
  int m_total;
  int m_run;
  bit m_timeout;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .STALL_TIMEOUT (TO),
    .CNT_WIDTH     (CW)
  ) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_alu_force_stall    (force_stall),
    .i_imem_busy          (imem_busy),
    .i_dmem_busy          (dmem_busy),
    .i_flush_req          (flush_req),
    .i_trap_req           (trap_req),
    .o_fetch_ce           (fetch_ce),
    .o_decoder_ce         (decoder_ce),
    .o_alu_ce             (alu_ce),
    .o_memoryaccess_ce    (memoryaccess_ce),
    .o_writeback_ce       (writeback_ce),
    .o_fetch_stall        (fetch_stall),
    .o_decoder_stall      (decoder_stall),
    .o_alu_stall          (alu_stall),
    .o_memoryaccess_stall (memoryaccess_stall),
    .o_decoder_flush      (decoder_flush),
    .o_alu_flush          (alu_flush),
    .o_pc_redirect        (pc_redirect),
    .o_trap_busy          (trap_busy),
    .o_stall_cycles       (stall_cycles),
    .o_stall_timeout      (stall_timeout)
  );

  assign ce_vec  = {fetch_ce, decoder_ce, alu_ce, memoryaccess_ce, writeback_ce};
  assign dut_vec = {ce_vec, fetch_stall, decoder_stall, alu_stall, memoryaccess_stall,
                    decoder_flush, alu_flush, pc_redirect, trap_busy, stall_timeout};

  // Number of leading stages that are frozen this cycle.
  function automatic int model_frozen();
    if (dmem_busy && m_v[3]) return 4;
    if (force_stall && m_v[2]) return 3;
    if (imem_busy) return 1;
    return 0;
  endfunction

  function automatic bit model_accept();
    return (m_mode == 1) && (model_frozen() < 3) && (trap_req || flush_req);
  endfunction

  function automatic logic [13:0] exp_vec();
    int fz;
    bit acc;
    fz  = model_frozen();
    acc = model_accept();
    return {m_v[0], m_v[1], m_v[2], m_v[3], m_v[4],
            logic'(fz >= 1), logic'(fz >= 3), logic'(fz >= 3), logic'(fz >= 4),
            acc, acc, acc, logic'(m_mode == 3), m_timeout};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 5; s++) m_v[s] = 1'b0;
    m_mode = 0; m_total = 0; m_run = 0; m_timeout = 1'b0;
  endtask

  task automatic model_advance();
    int fz;
    bit acc;
    bit n[5];
    fz  = model_frozen();
    acc = model_accept();
    for (int s = 4; s >= 1; s--) begin
      if (fz > s)          n[s] = m_v[s];
      else if (fz > s - 1) n[s] = 1'b0;
      else                 n[s] = m_v[s-1];
    end
    n[0] = 1'b1;
    if (fz >= 3) begin
      m_total = (m_total + 1) % (1 << CW);
      m_run++;
      if (m_run >= TO) m_timeout = 1'b1;
    end else begin
      m_run = 0;
    end
    case (m_mode)
      0: m_mode = 1;
      1: begin
        if (acc && trap_req) begin
          n[0] = 1'b0; n[1] = 1'b0; n[2] = 1'b0; n[3] = 1'b0;
          m_mode = 3;
        end else if (acc) begin
          n[1] = 1'b0; n[2] = 1'b0;
          m_mode = 2;
        end
      end
      2: m_mode = 1;
      default: begin
        n[1] = 1'b0; n[2] = 1'b0;
        if (!m_v[3] && !m_v[4]) begin
          m_mode = 1; n[0] = 1'b1;
        end else begin
          n[0] = 1'b0;
        end
      end
    endcase
    m_v = n;
  endtask

  task automatic drive(input bit fr, input bit tr, input bit fs, input bit ib, input bit db);
    flush_req = fr; trap_req = tr; force_stall = fs; imem_busy = ib; dmem_busy = db;
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic refill(input int n);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0);
    model_reset();
    #3;
    n_vec++;
    if (dut_vec !== 14'd0 || stall_cycles !== '0) begin
      n_err++;
      $display("FAIL reset: outputs=%b cycles=%0d required all zero", dut_vec, stall_cycles);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("test_reset: outputs=%b", dut_vec);
  endtask

  task automatic test_fill();
    logic [4:0] exp_ce;
    for (int k = 1; k <= 6; k++) begin
      drive(0, 0, 0, 0, 0);
      tick();
      #1;
      exp_ce = '0;
      for (int s = 0; s < 5; s++) if (k > s) exp_ce[4-s] = 1'b1;
      n_vec++;
      if (ce_vec !== exp_ce || stall_cycles !== '0) begin
        n_err++;
        $display("FAIL fill k=%0d: ce=%b cycles=%0d required ce=%b cycles=0", k, ce_vec, stall_cycles, exp_ce);
      end
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL fill_model k=%0d: got %b required %b", k, dut_vec, exp_vec());
      end
    end
    $display("test_fill: ce=%b", ce_vec);
  endtask

  task automatic test_alu_stall();
    drive(0, 0, 1, 0, 0);
    #1;
    n_vec++;
    if ({fetch_stall, decoder_stall, alu_stall, memoryaccess_stall} !== 4'b1110) begin
      n_err++;
      $display("FAIL alu_stall_flags: got %b required 1110",
               {fetch_stall, decoder_stall, alu_stall, memoryaccess_stall});
    end
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    n_vec++;
    if (memoryaccess_ce !== 1'b0 || alu_ce !== 1'b1 || stall_cycles !== CW'(1)) begin
      n_err++;
      $display("FAIL alu_stall_bubble: mem_ce=%b alu_ce=%b cycles=%0d required 0 1 1",
               memoryaccess_ce, alu_ce, stall_cycles);
    end
    n_vec++;
    if (dut_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL alu_stall_model: got %b required %b", dut_vec, exp_vec());
    end
    refill(3);
    $display("test_alu_stall: cycles=%0d", stall_cycles);
  endtask

  task automatic test_branch_flush();
    drive(1, 0, 0, 0, 0);
    #1;
    n_vec++;
    if ({pc_redirect, decoder_flush, alu_flush} !== 3'b111) begin
      n_err++;
      $display("FAIL flush_pulse: got %b required 111", {pc_redirect, decoder_flush, alu_flush});
    end
    tick();
    #1;
    n_vec++;
    if (decoder_ce !== 1'b0 || alu_ce !== 1'b0 || memoryaccess_ce !== 1'b1 || pc_redirect !== 1'b0) begin
      n_err++;
      $display("FAIL flush_kill: dec=%b alu=%b mem=%b redirect=%b required 0 0 1 0",
               decoder_ce, alu_ce, memoryaccess_ce, pc_redirect);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    n_vec++;
    if (dut_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL flush_model: got %b required %b", dut_vec, exp_vec());
    end
    refill(3);
    $display("test_branch_flush: ce=%b", ce_vec);
  endtask

  task automatic test_flush_blocked();
    drive(1, 0, 1, 0, 0);
    #1;
    n_vec++;
    if (pc_redirect !== 1'b0) begin
      n_err++;
      $display("FAIL flush_blocked: redirect=%b required 0", pc_redirect);
    end
    tick();
    drive(1, 0, 0, 0, 0);
    #1;
    n_vec++;
    if (pc_redirect !== 1'b1 || dut_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL flush_held: got %b required %b", dut_vec, exp_vec());
    end
    tick();
    refill(4);
    $display("test_flush_blocked: ce=%b", ce_vec);
  endtask

  task automatic test_trap_drain();
    bit accepted = 1'b0;
    bit done = 1'b0;
    int busy = 0;
    int blocked = 0;
    logic [13:0] e;
    for (int c = 0; c < 20 && !done; c++) begin
      drive(0, !accepted, 0, 0, c < 3);
      #1;
      e = exp_vec();
      n_vec++;
      if (dut_vec !== e) begin
        n_err++;
        $display("FAIL trap_model c=%0d: got %b required %b", c, dut_vec, e);
      end
      if (m_mode == 3) begin
        busy++;
        n_vec++;
        if (fetch_ce !== 1'b0) begin
          n_err++;
          $display("FAIL trap_fetch c=%0d: fetch_ce=%b required 0", c, fetch_ce);
        end
      end
      if (m_mode == 1 && busy > 0) begin
        done = 1'b1;
        n_vec++;
        if (fetch_ce !== 1'b1 || trap_busy !== 1'b0) begin
          n_err++;
          $display("FAIL trap_resume: fetch_ce=%b trap_busy=%b required 1 0", fetch_ce, trap_busy);
        end
      end
      if (!accepted && !e[2]) blocked++;
      if (e[2]) accepted = 1'b1;
      if (!done) tick();
    end
    n_vec++;
    if (!done || busy != 2 || blocked != 3) begin
      n_err++;
      $display("FAIL trap_sequence: done=%0d busy=%0d blocked=%0d required 1 2 3", done, busy, blocked);
    end
    refill(5);
    $display("test_trap_drain: busy=%0d blocked=%0d", busy, blocked);
  endtask

  task automatic test_trap_beats_flush();
    drive(1, 1, 0, 0, 0);
    #1;
    n_vec++;
    if (dut_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL both_req: got %b required %b", dut_vec, exp_vec());
    end
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    n_vec++;
    if (trap_busy !== 1'b1 || decoder_ce !== 1'b0 || memoryaccess_ce !== 1'b0) begin
      n_err++;
      $display("FAIL trap_wins: trap_busy=%b dec=%b mem=%b required 1 0 0",
               trap_busy, decoder_ce, memoryaccess_ce);
    end
    refill(8);
    $display("test_trap_beats_flush: trap_busy=%b", trap_busy);
  endtask

  task automatic test_timeout();
    reset_dut();
    refill(6);
    for (int k = 1; k <= TO; k++) begin
      drive(0, 0, 1, 0, 0);
      tick();
      #1;
      n_vec++;
      if (stall_timeout !== logic'(k >= TO) || stall_cycles !== CW'(k)) begin
        n_err++;
        $display("FAIL timeout k=%0d: timeout=%b cycles=%0d required %0d %0d",
                 k, stall_timeout, stall_cycles, k >= TO, k);
      end
    end
    refill(3);
    #1;
    n_vec++;
    if (stall_timeout !== 1'b1 || dut_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL timeout_sticky: got %b required %b", dut_vec, exp_vec());
    end
    $display("test_timeout: timeout=%b cycles=%0d", stall_timeout, stall_cycles);
  endtask

  task automatic test_reset_mid_drain();
    drive(0, 1, 0, 0, 0);
    #1;
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    n_vec++;
    if (trap_busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_drain_entry: trap_busy=%b required 1", trap_busy);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (dut_vec !== 14'd0 || stall_cycles !== '0) begin
      n_err++;
      $display("FAIL mid_drain_reset: outputs=%b cycles=%0d required all zero", dut_vec, stall_cycles);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    #1;
    n_vec++;
    if (ce_vec !== 5'b10000 || dut_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL restart: got %b required %b", dut_vec, exp_vec());
    end
    refill(5);
    $display("test_reset_mid_drain: ce=%b", ce_vec);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(99, 0) < 15, $urandom_range(99, 0) < 8, $urandom_range(99, 0) < 25,
            $urandom_range(99, 0) < 20, $urandom_range(99, 0) < 25);
      #1;
      n_vec++;
      if (dut_vec !== exp_vec() || stall_cycles !== CW'(m_total)) begin
        n_err++;
        bad++;
        $display("FAIL random i=%0d: got %b cycles=%0d required %b cycles=%0d",
                 i, dut_vec, stall_cycles, exp_vec(), m_total);
      end
      tick();
    end
    $display("test_random: 400 cycles, %0d bad, stall total=%0d", bad, m_total);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_alu_stall();
    test_branch_flush();
    test_flush_blocked();
    test_trap_drain();
    test_trap_beats_flush();
    test_timeout();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
